// File: rtl/fwrd_hist_unit_if.sv
// Result-broadcast and operand-lookup bundle for fwrd_hist_unit.
// ex_valid qualifies each FU slot for one cycle; there is no back-pressure (no ready), and lookups are purely combinational.
interface fwrd_hist_unit_if #(
    parameter int NUM_FUS      = 4,
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_W        = 6,
    parameter int DATA_W       = 32
);
    logic [NUM_FUS-1:0]                   ex_valid;
    logic [NUM_FUS-1:0][REG_W-1:0]        ex_dst;
    logic [NUM_FUS-1:0][DATA_W-1:0]       ex_val;
    logic [NUM_RD_PORTS-1:0][REG_W-1:0]   rd_reg;
    logic [NUM_RD_PORTS-1:0]              rd_hit;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0]  rd_val;

    modport master (
        output ex_valid, ex_dst, ex_val, rd_reg,
        input  rd_hit, rd_val
    );

    modport slave (
        input  ex_valid, ex_dst, ex_val, rd_reg,
        output rd_hit, rd_val
    );
endinterface

// File: rtl/fwrd_hist_unit.sv
// Operand forwarding from live FU broadcasts plus a HIST_DEPTH-stage result history.
// Optional feature macro: FWRD_ZERO_GUARD_EN (register 0 never forwards).
module fwrd_hist_unit #(
    parameter int NUM_FUS      = 4,
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_W        = 6,
    parameter int DATA_W       = 32,
    parameter int HIST_DEPTH   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    fwrd_hist_unit_if.slave bus
);

    logic [HIST_DEPTH-1:0][NUM_FUS-1:0]             hist_valid;
    logic [HIST_DEPTH-1:0][NUM_FUS-1:0][REG_W-1:0]  hist_dst;
    logic [HIST_DEPTH-1:0][NUM_FUS-1:0][DATA_W-1:0] hist_val;

    logic [NUM_FUS-1:0]                  live_valid;
    logic [NUM_RD_PORTS-1:0]             hit_c;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0] val_c;

    // Slots that may forward this cycle; the same qualification is what gets stored.
    always_comb begin
        live_valid = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
`ifdef FWRD_ZERO_GUARD_EN
            live_valid[f] = bus.ex_valid[f] && (bus.ex_dst[f] != '0);
`else
            live_valid[f] = bus.ex_valid[f];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_valid <= '0;
        end else if (flush) begin
            hist_valid <= '0;
        end else begin
            hist_valid[0] <= live_valid;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_valid[k] <= hist_valid[k-1];
            end
        end
    end

    // Payload carries no reset; it is only observed through hist_valid.
    always_ff @(posedge clk) begin
        hist_dst[0] <= bus.ex_dst;
        hist_val[0] <= bus.ex_val;
        for (int k = 1; k < HIST_DEPTH; k++) begin
            hist_dst[k] <= hist_dst[k-1];
            hist_val[k] <= hist_val[k-1];
        end
    end

    // Youngest age first, lowest FU index first within an age; first match sticks.
    always_comb begin
        hit_c = '0;
        val_c = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (!hit_c[p] && live_valid[f] && (bus.ex_dst[f] == bus.rd_reg[p])) begin
                    hit_c[p] = 1'b1;
                    val_c[p] = bus.ex_val[f];
                end
            end
            for (int k = 0; k < HIST_DEPTH; k++) begin
                for (int f = 0; f < NUM_FUS; f++) begin
                    if (!hit_c[p] && hist_valid[k][f] && (hist_dst[k][f] == bus.rd_reg[p])) begin
                        hit_c[p] = 1'b1;
                        val_c[p] = hist_val[k][f];
                    end
                end
            end
`ifdef FWRD_ZERO_GUARD_EN
            if (bus.rd_reg[p] == '0) begin
                hit_c[p] = 1'b0;
                val_c[p] = '0;
            end
`endif
        end
    end

    // Live inputs must not leak through while reset is held.
    assign bus.rd_hit = rst ? hit_c : '0;
    assign bus.rd_val = rst ? val_c : '0;

endmodule

// File: tb/tb_fwrd_hist_unit.sv
// Directed checks of fwrd_hist_unit: reset, miss, history aging, priority, flush, async reset.
module tb_fwrd_hist_unit;
  localparam int NUM_FUS      = 4;
  localparam int NUM_RD_PORTS = 2;
  localparam int REG_W        = 6;
  localparam int DATA_W       = 32;
  localparam int HIST_DEPTH   = 2;

  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  fwrd_hist_unit_if #(
    .NUM_FUS(NUM_FUS), .NUM_RD_PORTS(NUM_RD_PORTS), .REG_W(REG_W), .DATA_W(DATA_W)
  ) bus ();

  fwrd_hist_unit #(
    .NUM_FUS(NUM_FUS), .NUM_RD_PORTS(NUM_RD_PORTS), .REG_W(REG_W),
    .DATA_W(DATA_W), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, checks follow 1ns later
  task automatic clear_ex();
    bus.ex_valid = '0;
    bus.ex_dst   = '0;
    bus.ex_val   = '0;
  endtask

  task automatic bcast(input int fu, input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] val);
    bus.ex_valid[fu] = 1'b1;
    bus.ex_dst[fu]   = dst;
    bus.ex_val[fu]   = val;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clear_ex();
  endtask

  task automatic do_flush();
    next_cycle();
    bus.rd_reg = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clear_ex();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    clear_ex();
    bus.rd_reg = '0;
    @(negedge clk);
    bcast(0, 6'd4, 32'h44);
    bus.rd_reg[0] = 6'd4;
    #1;
    total++;
    if (bus.rd_hit !== 2'b00) begin bad++; $display("FAIL reset_hit got=%b exp=%b", bus.rd_hit, 2'b00); end
    total++;
    if (bus.rd_val[0] !== 32'h0) begin bad++; $display("FAIL reset_val got=%0h exp=%0h", bus.rd_val[0], 32'h0); end
    @(posedge clk);
    #1;
    total++;
    if (bus.rd_hit !== 2'b00) begin bad++; $display("FAIL reset_hold_hit got=%b exp=%b", bus.rd_hit, 2'b00); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.rd_hit !== 2'b01 || bus.rd_val[0] !== 32'h44) begin
      bad++; $display("FAIL reset_release_live got=%b/%0h exp=01/44", bus.rd_hit, bus.rd_val[0]);
    end
  endtask

  task automatic test_miss();
    do_flush();
    bcast(0, 6'd21, 32'd21);
    bus.rd_reg[0] = 6'd9;
    bus.rd_reg[1] = 6'd10;
    #1;
    total++;
    if (bus.rd_hit !== 2'b00) begin bad++; $display("FAIL miss_hit got=%b exp=%b", bus.rd_hit, 2'b00); end
    total++;
    if (bus.rd_val[0] !== 32'h0 || bus.rd_val[1] !== 32'h0) begin
      bad++; $display("FAIL miss_val got=%0h,%0h exp=0,0", bus.rd_val[0], bus.rd_val[1]);
    end
  endtask

  task automatic test_live_hist();
    do_flush();
    bcast(0, 6'd10, 32'd21);
    bus.rd_reg[0] = 6'd10;
    bus.rd_reg[1] = 6'd63;
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd21) begin
      bad++; $display("FAIL age0 got=%b/%0d exp=1/21", bus.rd_hit[0], bus.rd_val[0]);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd21) begin
      bad++; $display("FAIL age1 got=%b/%0d exp=1/21", bus.rd_hit[0], bus.rd_val[0]);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd21) begin
      bad++; $display("FAIL age2 got=%b/%0d exp=1/21", bus.rd_hit[0], bus.rd_val[0]);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b0 || bus.rd_val[0] !== 32'd0) begin
      bad++; $display("FAIL age3_expired got=%b/%0d exp=0/0", bus.rd_hit[0], bus.rd_val[0]);
    end
  endtask

  task automatic test_youngest();
    do_flush();
    bcast(1, 6'd6, 32'd32);
    bus.rd_reg[0] = 6'd6;
    next_cycle();
    bcast(3, 6'd6, 32'd64);
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd64) begin
      bad++; $display("FAIL young_live got=%b/%0d exp=1/64", bus.rd_hit[0], bus.rd_val[0]);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd64) begin
      bad++; $display("FAIL young_hist got=%b/%0d exp=1/64", bus.rd_hit[0], bus.rd_val[0]);
    end
  endtask

  task automatic test_priority();
    do_flush();
    bcast(1, 6'd8, 32'd16);
    bcast(2, 6'd8, 32'd99);
    bus.rd_reg[0] = 6'd8;
    bus.rd_reg[1] = 6'd8;
    #1;
    total++;
    if (bus.rd_hit !== 2'b11) begin bad++; $display("FAIL prio_hit got=%b exp=%b", bus.rd_hit, 2'b11); end
    total++;
    if (bus.rd_val[0] !== 32'd16 || bus.rd_val[1] !== 32'd16) begin
      bad++; $display("FAIL prio_live got=%0d,%0d exp=16,16", bus.rd_val[0], bus.rd_val[1]);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit !== 2'b11 || bus.rd_val[0] !== 32'd16 || bus.rd_val[1] !== 32'd16) begin
      bad++; $display("FAIL prio_hist got=%b/%0d,%0d exp=11/16,16", bus.rd_hit, bus.rd_val[0], bus.rd_val[1]);
    end
  endtask

  task automatic test_flush();
    do_flush();
    bcast(0, 6'd12, 32'd44);
    next_cycle();
    bcast(0, 6'd5, 32'd7);
    flush = 1'b1;
    bus.rd_reg[0] = 6'd5;
    bus.rd_reg[1] = 6'd12;
    #1;
    total++;
    if (bus.rd_hit !== 2'b11 || bus.rd_val[0] !== 32'd7 || bus.rd_val[1] !== 32'd44) begin
      bad++; $display("FAIL flush_cycle got=%b/%0d,%0d exp=11/7,44", bus.rd_hit, bus.rd_val[0], bus.rd_val[1]);
    end
    next_cycle();
    flush = 1'b0;
    #1;
    total++;
    if (bus.rd_hit !== 2'b00 || bus.rd_val[0] !== 32'd0 || bus.rd_val[1] !== 32'd0) begin
      bad++; $display("FAIL flush_after got=%b/%0d,%0d exp=00/0,0", bus.rd_hit, bus.rd_val[0], bus.rd_val[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_flush();
    bcast(0, 6'd3, 32'd33);
    next_cycle();
    bus.rd_reg[0] = 6'd3;
    bus.rd_reg[1] = 6'd63;
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd33) begin
      bad++; $display("FAIL rstmid_pre got=%b/%0d exp=1/33", bus.rd_hit[0], bus.rd_val[0]);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b0 || bus.rd_val[0] !== 32'd0) begin
      bad++; $display("FAIL rstmid_drop got=%b/%0d exp=0/0", bus.rd_hit[0], bus.rd_val[0]);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b0 || bus.rd_val[0] !== 32'd0) begin
      bad++; $display("FAIL rstmid_cleared got=%b/%0d exp=0/0", bus.rd_hit[0], bus.rd_val[0]);
    end
    bcast(1, 6'd7, 32'd70);
    next_cycle();
    bus.rd_reg[0] = 6'd7;
    #1;
    total++;
    if (bus.rd_hit[0] !== 1'b1 || bus.rd_val[0] !== 32'd70) begin
      bad++; $display("FAIL rstmid_capture got=%b/%0d exp=1/70", bus.rd_hit[0], bus.rd_val[0]);
    end
  endtask

  task automatic test_zero_reg();
    logic       exp_hit;
    logic [31:0] exp_val;
`ifdef FWRD_ZERO_GUARD_EN
    exp_hit = 1'b0;
    exp_val = 32'd0;
`else
    exp_hit = 1'b1;
    exp_val = 32'd5;
`endif
    do_flush();
    bcast(0, 6'd0, 32'd5);
    bus.rd_reg[0] = 6'd0;
    bus.rd_reg[1] = 6'd63;
    #1;
    total++;
    if (bus.rd_hit[0] !== exp_hit || bus.rd_val[0] !== exp_val) begin
      bad++; $display("FAIL zero_live got=%b/%0d exp=%b/%0d", bus.rd_hit[0], bus.rd_val[0], exp_hit, exp_val);
    end
    next_cycle();
    #1;
    total++;
    if (bus.rd_hit[0] !== exp_hit || bus.rd_val[0] !== exp_val) begin
      bad++; $display("FAIL zero_hist got=%b/%0d exp=%b/%0d", bus.rd_hit[0], bus.rd_val[0], exp_hit, exp_val);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_miss();
    test_live_hist();
    test_youngest();
    test_priority();
    test_flush();
    test_reset_mid();
    test_zero_reg();
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
